// File: rtl/data_memory.sv
// Byte-addressed, word-organised data memory for the single-cycle MIPS load/store stage.
// Latency: writes commit on the rising clock edge; reads are combinational (zero cycles).
// Backpressure: none, and a read and a write can proceed in the same cycle.
module data_memory #(
   parameter int depth = 50,
   parameter int width = 32,
   parameter int BPW   = 4,
   localparam int AW   = $clog2(depth * BPW)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [AW-1:0]    read_address,
   input  logic [AW-1:0]    write_address,
   input  logic [width-1:0] write_data,
   input  logic             write_en,
   input  logic             read_en,
   output logic [width-1:0] read_data
);

   localparam int OFS = $clog2(BPW);
   localparam int IW  = (depth > 1) ? $clog2(depth) : 1;

   logic [width-1:0] mem [depth];

   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic          rd_ok;
   logic          wr_ok;

   // The low OFS address bits select a byte within the word and are ignored.
   assign rd_idx = read_address >> OFS;
   assign wr_idx = write_address >> OFS;
   assign rd_ok  = (rd_idx < AW'(depth));
   assign wr_ok  = (wr_idx < AW'(depth));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < depth; i++) begin
            mem[i] <= '0;
         end
      end else if (write_en && wr_ok) begin
         mem[wr_idx[IW-1:0]] <= write_data;
      end
   end

   // Disabled or out-of-range reads return zero, so no X reaches the datapath.
   always_comb begin
      read_data = '0;
      if (read_en && rd_ok) begin
         read_data = mem[rd_idx[IW-1:0]];
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_data_memory;

   localparam int DEPTH = 50;
   localparam int WIDTH = 32;
   localparam int BPW   = 4;
   localparam int AW    = $clog2(DEPTH * BPW);

   logic             clk;
   logic             reset_n;
   logic [AW-1:0]    read_address;
   logic [AW-1:0]    write_address;
   logic [WIDTH-1:0] write_data;
   logic             write_en;
   logic             read_en;
   logic [WIDTH-1:0] read_data;

   int n_cmp;
   int n_err;

   logic [WIDTH-1:0] ref_mem [DEPTH];

   data_memory #(.depth(DEPTH), .width(WIDTH), .BPW(BPW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .read_address (read_address),
      .write_address(write_address),
      .write_data   (write_data),
      .write_en     (write_en),
      .read_en      (read_en),
      .read_data    (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ref_read(input logic en, input int addr);
      int idx;
      idx = addr / BPW;
      if (!en || idx >= DEPTH) return '0;
      return ref_mem[idx];
   endfunction

   task automatic ref_clear();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   task automatic ref_write(input int addr, input logic [WIDTH-1:0] d);
      if (addr / BPW < DEPTH) ref_mem[addr / BPW] = d;
   endtask

   task automatic test_reset();
      int addrs [3];
      addrs = '{0, 4, 196};
      @(negedge clk);
      reset_n  = 1'b0;
      write_en = 1'b0;
      read_en  = 1'b0;
      @(posedge clk);
      ref_clear();
      @(negedge clk);
      reset_n = 1'b1;
      read_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         read_address = AW'(addrs[i]);
         #1;
         n_cmp++;
         if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_read addr=%0d got=%h want=%h", addrs[i], read_data, 32'h0);
         end
      end
   endtask

   task automatic test_seq_write_read();
      int addrs [4];
      logic [WIDTH-1:0] want [4];
      addrs = '{4, 16, 20, 12};
      want  = '{32'hFAB1, 32'hFAB4, 32'hFAB5, 32'hFAB3};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         write_address = AW'(4 * i);
         write_data    = 32'hFAB0 + WIDTH'(i);
         write_en      = 1'b1;
         @(posedge clk);
         ref_write(4 * i, 32'hFAB0 + WIDTH'(i));
      end
      @(negedge clk);
      write_en = 1'b0;
      read_en  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         read_address = AW'(addrs[i]);
         #1;
         n_cmp++;
         if (read_data !== want[i] || read_data !== ref_read(1'b1, addrs[i])) begin
            n_err++;
            $display("FAIL seq_read addr=%0d got=%h want=%h", addrs[i], read_data, want[i]);
         end
         #14;
      end
   endtask

   task automatic test_read_en_alias();
      int addrs [2];
      addrs = '{5, 7};
      @(negedge clk);
      read_en      = 1'b0;
      read_address = AW'(4);
      #1;
      n_cmp++;
      if (read_data !== 32'h0) begin
         n_err++;
         $display("FAIL read_en_low got=%h want=%h", read_data, 32'h0);
      end
      read_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         read_address = AW'(addrs[i]);
         #1;
         n_cmp++;
         if (read_data !== 32'hFAB1) begin
            n_err++;
            $display("FAIL alias addr=%0d got=%h want=%h", addrs[i], read_data, 32'hFAB1);
         end
      end
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      write_address = AW'(200);
      write_data    = 32'h1234;
      write_en      = 1'b1;
      @(posedge clk);
      ref_write(200, 32'h1234);
      @(negedge clk);
      write_en = 1'b0;
      read_en  = 1'b1;
      read_address = AW'(0);
      #1;
      n_cmp++;
      if (read_data !== 32'hFAB0) begin
         n_err++;
         $display("FAIL oor_word0 got=%h want=%h", read_data, 32'hFAB0);
      end
      for (int i = 0; i < DEPTH; i++) begin
         read_address = AW'(i * BPW);
         #1;
         n_cmp++;
         if (read_data !== ref_read(1'b1, i * BPW)) begin
            n_err++;
            $display("FAIL oor_scan word=%0d got=%h want=%h", i, read_data, ref_read(1'b1, i * BPW));
         end
      end
      for (int a = 200; a < 256; a += 27) begin
         read_address = AW'(a);
         #1;
         n_cmp++;
         if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL oor_read addr=%0d got=%h want=%h", a, read_data, 32'h0);
         end
      end
   endtask

   task automatic test_rdw_reset();
      @(negedge clk);
      read_en       = 1'b1;
      read_address  = AW'(8);
      write_address = AW'(8);
      write_data    = 32'hBEEF;
      write_en      = 1'b1;
      #1;
      n_cmp++;
      if (read_data !== 32'hFAB2) begin
         n_err++;
         $display("FAIL rdw_before got=%h want=%h", read_data, 32'hFAB2);
      end
      @(posedge clk);
      ref_write(8, 32'hBEEF);
      #1;
      n_cmp++;
      if (read_data !== 32'hBEEF) begin
         n_err++;
         $display("FAIL rdw_after got=%h want=%h", read_data, 32'hBEEF);
      end
      @(negedge clk);
      reset_n    = 1'b0;
      write_data = 32'h5555;
      @(posedge clk);
      ref_clear();
      #1;
      reset_n  = 1'b1;
      write_en = 1'b0;
      #1;
      n_cmp++;
      if (read_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_priority got=%h want=%h", read_data, 32'h0);
      end
   endtask

   task automatic test_random();
      int wa, ra;
      logic we, re, rst;
      logic [WIDTH-1:0] wd;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 39) == 0);
         we  = ($urandom_range(0, 2) != 0);
         re  = ($urandom_range(0, 5) != 0);
         wa  = (n % 3 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 60);
         ra  = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 255);
         wd  = $urandom;
         reset_n       = ~rst;
         write_en      = we;
         write_address = AW'(wa);
         write_data    = wd;
         read_en       = re;
         read_address  = AW'(ra);
         #1;
         n_cmp++;
         if (read_data !== ref_read(re, ra)) begin
            n_err++;
            $display("FAIL rand_pre n=%0d addr=%0d got=%h want=%h", n, ra, read_data, ref_read(re, ra));
         end
         @(posedge clk);
         if (rst) ref_clear();
         else if (we) ref_write(wa, wd);
         #1;
         n_cmp++;
         if (read_data !== ref_read(re, ra)) begin
            n_err++;
            $display("FAIL rand_post n=%0d addr=%0d got=%h want=%h", n, ra, read_data, ref_read(re, ra));
         end
      end
      @(negedge clk);
      reset_n  = 1'b1;
      write_en = 1'b0;
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      reset_n       = 1'b1;
      write_en      = 1'b0;
      read_en       = 1'b0;
      read_address  = '0;
      write_address = '0;
      write_data    = '0;
      ref_clear();
      test_reset();
      test_seq_write_read();
      test_read_en_alias();
      test_out_of_range();
      test_rdw_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised, byte-addressed data memory for the single-cycle MIPS datapath.
- Serves the load/store stage.
- Writes are synchronous, on the rising clock edge.
- Reads are combinational (asynchronous), so a load completes in the same cycle.
- Separate read and write address ports allow a simultaneous read and write.

Parameters:
- depth, 50, number of words stored.
- width, 32, bits per word (data port width).
- BPW, 4, bytes per word; address-to-word stride. Must be a power of two ≥1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- read_address  input  $clog2(depth*BPW)  byte address for reads (8 bits at defaults).
- write_address  input  $clog2(depth*BPW)  byte address for writes (8 bits at defaults).
- write_data  input  width  word to store.
- write_en  input  1  write strobe, active high.
- read_en  input  1  read enable, active high.
- read_data  output  width  word read; combinational.

Behaviour:
- Storage: depth words of width bits.
- Word index = byte address >> $clog2(BPW). The low $clog2(BPW) address bits are ignored, so unaligned addresses map to the containing word. No alignment fault is raised.
- Reset:
  - One clock; reset is synchronous and active-low.
  - On a rising edge with reset_n=0, every word is cleared to 0.
  - Reset has priority over write_en; no write occurs in that cycle.
  - Asserting reset mid-operation discards nothing else (no other state exists).
- Write:
  - On a rising edge with reset_n=1 and write_en=1, mem[write index] <= write_data.
  - If write index ≥ depth (e.g. byte address ≥200 at defaults), the write is dropped and no word changes.
  - write_en=0 leaves memory unchanged.
- Read:
  - read_data = mem[read index] whenever read_en=1 and read index < depth. Zero latency; it follows address changes without waiting for a clock edge.
  - read_en=0 forces read_data = 0.
  - An out-of-range read index forces read_data = 0.
- Read-during-write, same word:
  - Before the edge, read_data shows the old contents.
  - Immediately after the edge, it shows write_data. No forwarding.
- Reset output: after a reset edge, any enabled read returns 0 until that word is written.
- Non-default width/depth/BPW must scale with no other change. The address width is always $clog2(depth*BPW).
- No X may propagate to read_data once reset has been applied.

Test Plan:
- Reset then read: hold reset_n=0 for one edge, then read_en=1, read_address=0/4/196 -> read_data=0 each.
- Sequential writes then reads:
  - Write 0xFAB0..0xFAB5 to byte addresses 0,4,8,12,16,20 on consecutive edges, then write_en=0 and read_en=1.
  - Read address 4 -> 0xFAB1; 16 -> 0xFAB4; 20 -> 0xFAB5; 12 -> 0xFAB3.
  - Each value must appear without waiting for a clock edge (address changes off-edge, 15 ns apart).
- Read enable and aliasing:
  - read_en=0 with address 4 holding 0xFAB1 -> read_data=0.
  - read_address=5 or 7 -> 0xFAB1 (low bits ignored).
- Out-of-range:
  - Write 0x1234 to byte address 200 with write_en=1 -> no word changes (address 0 still 0xFAB0).
  - Read address 200 -> 0.
- Read-during-write and reset priority:
  - read_address=write_address=8, write 0xBEEF -> read_data=0xFAB2 before the edge, 0xBEEF after.
  - Then reset_n=0 together with write_en=1 at address 8 -> after the edge, word 8 reads 0.
